// File: rtl/vga_sync.sv
// 640x480@60 Hz VGA timing generator: pixel-enable divider, pixel/line counters,
// registered active-low syncs, visible-area flag and a once-per-frame blanking pulse.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       tick_reg;
  logic       h_wrap;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [9:0] next_h;
  logic [9:0] next_v;

  always_comb begin
    h_wrap = (h_count == H_MAX);
    next_h = h_count;
    next_v = v_count;
    if (tick_reg) begin
      next_h = h_wrap ? 10'd0 : h_count + 10'd1;
      if (h_wrap)
        next_v = (v_count == V_MAX) ? 10'd0 : v_count + 10'd1;
    end
  end

  // Syncs are decoded from the next counter values so they land on the same edge as the coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_reg <= 1'b0;
      h_count  <= 10'd0;
      v_count  <= 10'd0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else begin
      tick_reg <= ~tick_reg;
      if (tick_reg) begin
        h_count <= next_h;
        v_count <= next_v;
        hsync   <= ~((next_h >= HS_START) && (next_h <= HS_END));
        vsync   <= ~((next_v >= VS_START) && (next_v <= VS_END));
      end
    end
  end

  assign p_tick     = tick_reg;
  assign pixel_x    = h_count;
  assign pixel_y    = v_count;
  assign video_on   = (h_count < H_VIS) && (v_count < V_VIS);
  assign frame_tick = tick_reg && (h_count == 10'd0) && (v_count == V_VIS);

endmodule

// File: doc/vga_sync.md
# vga_sync

Timing generator at the front of the video pipeline. Divides the 50 MHz system clock into a 25 MHz pixel enable and produces 640x480@60 Hz horizontal/vertical sync, the current pixel coordinates and a visible-area flag. It also issues one per-frame pulse during vertical blanking. `pixel_x`/`pixel_y` feed the background and sprite renderers; `frame_tick` drives their `update_signal` input so scrolling advances once per frame, outside the visible area.

## Interface
Parameters (all counts in pixels or lines):
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: hsync pulse width
- `H_BACK`, 48: horizontal back porch
- `V_DISPLAY`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vsync pulse width
- `V_BACK`, 33: vertical back porch

Ports:
- `clk`  in  1  system clock, 50 MHz; all logic on its rising edge
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge
- `hsync`  out  1  horizontal sync, active-low, registered
- `vsync`  out  1  vertical sync, active-low, registered
- `video_on`  out  1  high while (`pixel_x` < H_DISPLAY) and (`pixel_y` < V_DISPLAY)
- `p_tick`  out  1  pixel enable, high one `clk` in two
- `frame_tick`  out  1  one-`clk` pulse per frame at the start of vertical blanking
- `pixel_x`  out  10  current column, 0 .. H_TOTAL-1
- `pixel_y`  out  10  current line, 0 .. V_TOTAL-1

## Operation
- H_TOTAL = sum of the H_* parameters (default 800). V_TOTAL = sum of the V_* parameters (default 525). Both totals must be ≤ 1024, because the counters are 10 bits and unsigned.
- Divider: 1-bit `tick_reg` toggles on every `clk`. `p_tick` = `tick_reg`, so it is high on odd cycles counted from reset release.
- Horizontal counter: on each `clk` with `p_tick` = 1, it increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on a `p_tick` cycle where the horizontal counter wraps. It increments, or wraps V_TOTAL-1 → 0.
- Sync generation, computed from the *next* counter values and registered on `p_tick`, so sync stays aligned with the coordinates it accompanies:
  - `hsync` = 0 when next_h is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. Default range is 656..751.
  - `vsync` = 0 when next_v is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]. Default range is 490..491.
- `pixel_x`/`pixel_y` are the counter registers driven directly. `video_on` is combinational from those registers.
- `frame_tick` = `p_tick` AND (h_count == 0) AND (v_count == V_DISPLAY). It fires exactly once per V_TOTAL*H_TOTAL pixels.
- No other state machine exists. The block free-runs from reset with no inputs other than `clk` and `reset`.

## Timing
- Reset values, visible in the cycle after `reset` is sampled high:
  - `tick_reg`, `p_tick`, `pixel_x`, `pixel_y`: 0
  - `hsync`, `vsync`: 1
  - `video_on`: 1
  - `frame_tick`: 0
- Reset asserted mid-frame: everything returns to the values above on the next edge, regardless of counter position or divider phase. No partial sync pulse is stretched.
- First `p_tick` after reset release occurs on the 1st cycle after release. The first coordinate change (`pixel_x` 0→1) follows on the next edge.
- One pixel = 2 `clk` cycles. Line = 1600 cycles; frame = 840 000 cycles (16.8 ms) at defaults.
- Coordinates, `hsync`, `vsync` and `video_on` change only on the edge that ends a `p_tick` cycle. Between those edges they are stable for 2 cycles.
- Simultaneous wraps: at (799, 524) the next `p_tick` takes both counters to (0, 0) on the same edge. `vsync` is already 1 there and stays 1.
- `frame_tick` coincides with `p_tick`. It is never asserted while `video_on` = 1.

## Test plan
- Reset then release: check `hsync`=1, `vsync`=1, `pixel_x`=0, `pixel_y`=0, `frame_tick`=0. `p_tick` must alternate 1,0,1,… starting on the first cycle after release.
- Run one full line: `pixel_x` takes 0..799 and wraps. Over the line, `hsync` must be low for exactly 192 `clk` cycles, with `pixel_x` at 656..751. `video_on` must be high for exactly 1280 cycles. `pixel_y` increments only at the 799→0 step.
- Run one full frame: check `vsync` is low only on lines 490–491 (3200 cycles). Check `frame_tick` fires once, when (x, y) = (0, 480). The next frame's `frame_tick` must come exactly 840 000 cycles later.
- Corner wrap: at (799, 524), the next `p_tick` edge must give (0, 0) with `video_on`=1, `hsync`=1, `vsync`=1.
- Reset mid-frame: assert `reset` for one cycle at (700, 491), inside both the hsync and vsync pulses. The next edge must give (0, 0), `hsync`=1, `vsync`=1, `tick_reg`=0.
- Shrunken parameters (H 8/2/2/2, V 4/1/1/1): check line length 14 pixels and frame length 7 lines. Check `hsync` is low at x=10..11, `vsync` is low at y=5, and `frame_tick` fires at (0, 4).
